// File: rtl/mux_inv_scan.sv
// mux_inv_scan: registered CHANNELS-to-1 multiplexer with a per-channel
// invert option. Channel k is presented as data_in[k] XOR {WIDTH{inv_mask[k]}}.
// In manual mode the channel comes from sel_in every cycle. In scan mode a
// small FSM walks every channel, holding each for HOLD cycles, then pulses
// done. All outputs come straight from flops.
module mux_inv_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int HOLD     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       inv_mask,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      start,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_sel,
  output logic                      y_valid,
  output logic                      sel_err,
  output logic                      busy,
  output logic                      done
);

  // Hold counter needs at least one bit even when HOLD == 1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [SEL_W-1:0] CNT_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [HW-1:0]    HCNT_LAST = HW'(HOLD - 1);
  // One extra bit so the range test also works when CHANNELS == 2**SEL_W.
  localparam logic [SEL_W:0]   CH_N      = (SEL_W + 1)'(CHANNELS);

  // Reject parameter sets the counters and select path cannot represent.
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("mux_inv_scan: CHANNELS must be in 2..16");
  end
  if ((1 << SEL_W) < CHANNELS) begin : g_bad_sel_w
    $error("mux_inv_scan: SEL_W too narrow for CHANNELS");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("mux_inv_scan: HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Channel function: pick channel idx and apply its invert bit.
  // Indices at or beyond CHANNELS yield zero.
  function automatic logic [WIDTH-1:0] chan_f(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [CHANNELS-1:0]       m,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        r = d[k*WIDTH +: WIDTH] ^ {WIDTH{m[k]}};
      end
    end
    return r;
  endfunction

  // Control state
  state_t            r_state;
  logic [SEL_W-1:0]  r_cnt;
  logic [HW-1:0]     r_hcnt;

  // Output registers
  logic [WIDTH-1:0]  r_y;
  logic [SEL_W-1:0]  r_y_sel;
  logic              r_y_valid;
  logic              r_sel_err;
  logic              r_busy;
  logic              r_done;

  // Next-state values
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  w_cnt_nxt;
  logic [HW-1:0]     w_hcnt_nxt;
  logic [WIDTH-1:0]  w_y_nxt;
  logic [SEL_W-1:0]  w_y_sel_nxt;
  logic              w_y_valid_nxt;
  logic              w_sel_err_nxt;
  logic              w_done_nxt;

  logic              w_sel_ok;
  logic [WIDTH-1:0]  w_f_sel;
  logic [WIDTH-1:0]  w_f_cnt;

  // Channel values for the manual select and for the scan counter.
  always_comb begin
    w_sel_ok = ({1'b0, sel_in} < CH_N);
    w_f_sel  = chan_f(data_in, inv_mask, sel_in);
    w_f_cnt  = chan_f(data_in, inv_mask, r_cnt);
  end

  // Next-state and next-output logic; every value defaults to hold or idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_y_nxt       = r_y;
    w_y_sel_nxt   = r_y_sel;
    w_y_valid_nxt = 1'b0;
    w_sel_err_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!mode) begin
          w_y_sel_nxt = sel_in;
          if (w_sel_ok) begin
            w_y_nxt       = w_f_sel;
            w_y_valid_nxt = 1'b1;
          end else begin
            w_y_nxt       = '0;
            w_sel_err_nxt = 1'b1;
          end
        end else if (start) begin
          w_state_nxt = S_SCAN;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
        end
      end

      S_SCAN: begin
        // data_in and inv_mask are read live on every scan edge.
        w_y_nxt       = w_f_cnt;
        w_y_sel_nxt   = r_cnt;
        w_y_valid_nxt = (r_hcnt == '0);
        if (r_hcnt == HCNT_LAST) begin
          w_hcnt_nxt = '0;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + SEL_W'(1);
          end
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end

      S_DONE: begin
        // First DONE cycle raises done; the following edge returns to IDLE,
        // so busy stays high for the cycle in which done is visible.
        if (!r_done) begin
          w_done_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_hcnt_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  // FSM state and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // Registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_sel   <= '0;
      r_y_valid <= 1'b0;
      r_sel_err <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_y       <= w_y_nxt;
      r_y_sel   <= w_y_sel_nxt;
      r_y_valid <= w_y_valid_nxt;
      r_sel_err <= w_sel_err_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign y       = r_y;
  assign y_sel   = r_y_sel;
  assign y_valid = r_y_valid;
  assign sel_err = r_sel_err;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_mux_inv_scan.sv
// Bench for mux_inv_scan: three builds (4 channels HOLD=1, 3 channels HOLD=1,
// 4 channels HOLD=3) on a shared clock and reset.
module tb_mux_inv_scan;

  logic clk;
  logic rst_n;

  // Build A: CHANNELS=4, HOLD=1
  logic [31:0] a_data;
  logic [3:0]  a_mask;
  logic        a_mode, a_start;
  logic [1:0]  a_sel;
  logic [7:0]  a_y;
  logic [1:0]  a_ysel;
  logic        a_yv, a_err, a_busy, a_done;

  // Build B: CHANNELS=3, HOLD=1
  logic [23:0] b_data;
  logic [2:0]  b_mask;
  logic        b_mode, b_start;
  logic [1:0]  b_sel;
  logic [7:0]  b_y;
  logic [1:0]  b_ysel;
  logic        b_yv, b_err, b_busy, b_done;

  // Build C: CHANNELS=4, HOLD=3
  logic [31:0] c_data;
  logic [3:0]  c_mask;
  logic        c_mode, c_start;
  logic [1:0]  c_sel;
  logic [7:0]  c_y;
  logic [1:0]  c_ysel;
  logic        c_yv, c_err, c_busy, c_done;

  mux_inv_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .HOLD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .inv_mask(a_mask),
    .mode(a_mode), .sel_in(a_sel), .start(a_start),
    .y(a_y), .y_sel(a_ysel), .y_valid(a_yv), .sel_err(a_err),
    .busy(a_busy), .done(a_done)
  );

  mux_inv_scan #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .inv_mask(b_mask),
    .mode(b_mode), .sel_in(b_sel), .start(b_start),
    .y(b_y), .y_sel(b_ysel), .y_valid(b_yv), .sel_err(b_err),
    .busy(b_busy), .done(b_done)
  );

  mux_inv_scan #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .HOLD(3)) u_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_data), .inv_mask(c_mask),
    .mode(c_mode), .sel_in(c_sel), .start(c_start),
    .y(c_y), .y_sel(c_ysel), .y_valid(c_yv), .sel_err(c_err),
    .busy(c_busy), .done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] y;
    logic [1:0] sel;
    logic       v;
    logic       e;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit         which;   // 0 = build A, 1 = build B
    logic [1:0] sel;
    logic [3:0] mask;
    logic [7:0] ey;
    logic       ev;
    logic       ee;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string nm, output exp_t e);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: output seen with no expected entry queued", nm);
      e = '{8'h00, 2'd0, 1'b0, 1'b0};
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Reference channel function for the 4-channel builds.
  function automatic logic [7:0] ref_f(input logic [31:0] d, input logic [3:0] m, input int ch);
    return d[ch*8 +: 8] ^ {8{m[ch]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[10];
    exp_t  e;
    logic [7:0] last_a_y;
    int    nvalid;

    rst_n   = 1'b0;
    a_data  = 32'h44332211; a_mask = 4'b0010; a_mode = 1'b0; a_start = 1'b0; a_sel = 2'd0;
    b_data  = 24'h332211;   b_mask = 3'b010;  b_mode = 1'b0; b_start = 1'b0; b_sel = 2'd0;
    c_data  = 32'h44332211; c_mask = 4'b0010; c_mode = 1'b0; c_start = 1'b0; c_sel = 2'd0;

    // Reset state
    tick();
    tick();
    chk("rst_y",     a_y,    0);
    chk("rst_ysel",  a_ysel, 0);
    chk("rst_valid", a_yv,   0);
    chk("rst_err",   a_err,  0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_done",  a_done, 0);
    rst_n = 1'b1;

    // Manual-mode vectors
    vecs[0] = '{1'b0, 2'd1, 4'b0010, 8'hDD, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 2'd3, 4'b0010, 8'h44, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 4'b0010, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'd2, 4'b0100, 8'hCC, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 4'b1111, 8'hEE, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 4'b0010, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'd0, 4'b0010, 8'h11, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 4'b0010, 8'hDD, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 2'd2, 4'b0100, 8'hCC, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 2'd2, 4'b0010, 8'h33, 1'b1, 1'b0};

    last_a_y = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].which) begin
        a_mode = 1'b0; a_sel = vecs[i].sel; a_mask = vecs[i].mask;
      end else begin
        b_mode = 1'b0; b_sel = vecs[i].sel; b_mask = vecs[i].mask[2:0];
      end
      sb.push_back('{vecs[i].ey, vecs[i].sel, vecs[i].ev, vecs[i].ee});
      tick();
      sb_pop("man_sb", e);
      if (!vecs[i].which) begin
        chk($sformatf("man_a%0d_y", i),    a_y,    e.y);
        chk($sformatf("man_a%0d_ysel", i), a_ysel, e.sel);
        chk($sformatf("man_a%0d_v", i),    a_yv,   e.v);
        chk($sformatf("man_a%0d_err", i),  a_err,  e.e);
        last_a_y = vecs[i].ey;
      end else begin
        chk($sformatf("man_b%0d_y", i),    b_y,    e.y);
        chk($sformatf("man_b%0d_ysel", i), b_ysel, e.sel);
        chk($sformatf("man_b%0d_v", i),    b_yv,   e.v);
        chk($sformatf("man_b%0d_err", i),  b_err,  e.e);
      end
    end

    // Scan mode selected but no start: outputs hold, valid drops
    a_mode = 1'b1; a_start = 1'b0; a_mask = 4'b0010; a_sel = 2'd1;
    tick();
    chk("idle_scan_v",    a_yv,   0);
    chk("idle_scan_err",  a_err,  0);
    chk("idle_scan_hold", a_y,    last_a_y);
    chk("idle_scan_busy", a_busy, 0);

    // Scan HOLD=1: start at E0, results after E1..E4, done after E5
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("scan1_e0_busy", a_busy, 1);
    chk("scan1_e0_v",    a_yv,   0);
    sb.push_back('{8'h11, 2'd0, 1'b1, 1'b0});
    sb.push_back('{8'hDD, 2'd1, 1'b1, 1'b0});
    sb.push_back('{8'h33, 2'd2, 1'b1, 1'b0});
    sb.push_back('{8'h44, 2'd3, 1'b1, 1'b0});
    nvalid = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("scan1_e%0d_v", i), a_yv, (i <= 4));
      if (a_yv) begin
        nvalid++;
        sb_pop("scan1_sb", e);
        chk($sformatf("scan1_e%0d_y", i),    a_y,    e.y);
        chk($sformatf("scan1_e%0d_ysel", i), a_ysel, e.sel);
      end
      chk($sformatf("scan1_e%0d_done", i), a_done, (i == 5));
      chk($sformatf("scan1_e%0d_busy", i), a_busy, (i <= 5));
      chk($sformatf("scan1_e%0d_err", i),  a_err,  0);
    end
    chk("scan1_nvalid", nvalid, 4);
    chk("scan1_drain",  sb.size(), 0);
    chk("scan1_hold_y", a_y, 8'h44);
    chk("scan1_hold_ysel", a_ysel, 2'd3);

    // Scan HOLD=3 with control toggling and a live inv_mask change
    c_mode = 1'b1; c_mask = 4'b0010; c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("scan3_e0_busy", c_busy, 1);
    sb.push_back('{8'h11, 2'd0, 1'b1, 1'b0});
    sb.push_back('{8'hDD, 2'd1, 1'b1, 1'b0});
    sb.push_back('{8'h33, 2'd2, 1'b1, 1'b0});
    sb.push_back('{8'hBB, 2'd3, 1'b1, 1'b0});
    for (int i = 1; i <= 14; i++) begin
      int ch;
      c_mode  = 1'($urandom_range(0, 1));
      c_start = 1'($urandom_range(0, 1));
      c_sel   = 2'($urandom_range(0, 3));
      if (i == 8) c_mask = 4'b1111;
      tick();
      ch = (i <= 12) ? (i - 1) / 3 : 3;
      chk($sformatf("scan3_e%0d_v", i), c_yv, ((i <= 12) && ((i - 1) % 3 == 0)));
      chk($sformatf("scan3_e%0d_y", i), c_y, ref_f(c_data, (i >= 8) ? 4'b1111 : 4'b0010, ch));
      chk($sformatf("scan3_e%0d_ysel", i), c_ysel, ch);
      if (c_yv) begin
        sb_pop("scan3_sb", e);
        chk($sformatf("scan3_e%0d_sby", i), c_y, e.y);
      end
      if (i == 8) chk("scan3_live_cc", c_y, 8'hCC);
      chk($sformatf("scan3_e%0d_done", i), c_done, (i == 13));
      chk($sformatf("scan3_e%0d_busy", i), c_busy, (i <= 13));
      chk($sformatf("scan3_e%0d_err", i),  c_err,  0);
    end
    chk("scan3_drain", sb.size(), 0);
    c_mode = 1'b0; c_start = 1'b0; c_sel = 2'd0;

    // Asynchronous reset in the middle of a scan
    a_mode = 1'b1; a_mask = 4'b0010; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("mid_pre_busy", a_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y",    a_y,    0);
    chk("mid_rst_ysel", a_ysel, 0);
    chk("mid_rst_v",    a_yv,   0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_post_busy", a_busy, 0);
    chk("mid_post_v",    a_yv,   0);
    chk("mid_post_y",    a_y,    0);
    a_mode = 1'b0; a_sel = 2'd3;
    tick();
    chk("mid_man_y", a_y,  8'h44);
    chk("mid_man_v", a_yv, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_inv_scan.md
Name: mux_inv_scan

Overview:
- Parameterised, registered CHANNELS-to-1 multiplexer with a per-channel invert option. Each channel is presented either as-is or bitwise inverted, which generalises the single-bit mux(a, not(a), c) cell.
- Manual mode: one channel is selected every cycle.
- Scan mode: an internal FSM steps through all channels in turn. This lets the bench/controller sweep the full truth table without external sequencing.
- Sits between test-pattern sources and the result checker in the lab datapath.

Parameters:
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select width; SEL_W >= clog2(CHANNELS)
- HOLD, 1, cycles each channel is held in scan mode (>= 1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- inv_mask  in  CHANNELS  bit k=1: channel k is output inverted
- mode  in  1  0 = manual, 1 = scan
- sel_in  in  SEL_W  manual channel select
- start  in  1  scan start pulse; sampled only in IDLE with mode=1
- y  out  WIDTH  registered selected (optionally inverted) data
- y_sel  out  SEL_W  channel index that produced y
- y_valid  out  1  y/y_sel carry a new valid result this cycle
- sel_err  out  1  manual sel_in >= CHANNELS
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of scan

Behaviour:
- Channel function: f(k) = data_in[k] XOR {WIDTH{inv_mask[k]}}.
- Reset (rst_n=0, asynchronous, any time including mid-scan):
  - FSM goes to IDLE; scan counter and hold counter cleared.
  - y=0, y_sel=0, y_valid=0, sel_err=0, busy=0, done=0.
- All outputs are registered. Nothing combinational from inputs to outputs.
- FSM states: IDLE, SCAN, DONE. busy = (state != IDLE).
- IDLE, mode=0 (manual), each edge:
  - If sel_in < CHANNELS: y <= f(sel_in), y_sel <= sel_in, y_valid <= 1, sel_err <= 0. Latency is 1 cycle.
  - If sel_in >= CHANNELS: y <= 0, y_sel <= sel_in, y_valid <= 0, sel_err <= 1.
- IDLE, mode=1, start=0: y_valid <= 0, sel_err <= 0, y/y_sel hold.
- IDLE, mode=1, start=1: state <= SCAN, cnt <= 0, hcnt <= 0, y_valid <= 0.
- SCAN, each edge:
  - y <= f(cnt), y_sel <= cnt, y_valid <= (hcnt == 0), so y_valid is exactly one pulse per channel.
  - If hcnt == HOLD-1: hcnt <= 0; if cnt == CHANNELS-1 then state <= DONE, else cnt <= cnt+1.
  - Otherwise hcnt <= hcnt+1.
- DONE: done <= 1 for exactly one cycle, y_valid <= 0, y/y_sel hold last channel; next edge state <= IDLE, done <= 0.
- Scan length: start sampled at edge E0 gives channel results after E1..E(CHANNELS*HOLD), done high after E(CHANNELS*HOLD+1), busy low after E(CHANNELS*HOLD+2).
- In SCAN/DONE, start, mode, sel_in are ignored; sel_err held 0.
- data_in / inv_mask are sampled live on every SCAN edge (not latched at start).
- Counter wrap: cnt never exceeds CHANNELS-1; hcnt never exceeds HOLD-1.

Test Plan (WIDTH=8, CHANNELS=4, data_in = {8'h44, 8'h33, 8'h22, 8'h11}, inv_mask = 4'b0010):
- Reset mid-operation: assert rst_n=0 between edges during SCAN -> y=00, y_valid=0, busy=0, done=0 immediately, without waiting for clk; FSM in IDLE after release.
- Manual mode=0: sel_in=1 -> next cycle y=8'hDD, y_sel=1, y_valid=1; sel_in=3 -> y=8'h44.
- Out of range (CHANNELS=3 build, sel_in=3) -> y=00, y_valid=0, sel_err=1; sel_in=0 -> sel_err=0, y=8'h11.
- Scan HOLD=1: start pulse at E0 -> after E1..E4 y = 11, DD, 33, 44 with y_sel 0..3 and y_valid=1 each; done=1 after E5 only; busy=0 after E6.
- Scan HOLD=3: y_valid pulses only on the first cycle of each 3-cycle hold; total busy window 14 cycles; toggle mode and start during the scan -> no effect.
- Live sampling: change inv_mask to 4'b1111 while channel 2 is held -> the next SCAN edge gives y=8'hCC.
